// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 7;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset level.
module sync_2ff #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start, DBIT data bits LSB-first, optional parity, stop.
// Parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       parity_err
);

  rx_state_e  state_q, state_d;
  logic [4:0] s_q, s_d;
  logic [2:0] n_q, n_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] dout_d;
  logic       ferr_d;
  logic       done_d;
  logic       rx_s, rx_q;
  logic [7:0] aligned;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Data bits enter at the MSB, so the last DBIT bits sit at the top of the register.
  assign aligned = shift_q >> (8 - DBIT);

`ifdef UART_RX_PARITY_EN
  logic pbit_q, pbit_d;
  logic perr_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RX_IDLE;
      s_q          <= 5'd0;
      n_q          <= 3'd0;
      shift_q      <= 8'd0;
      dout         <= 8'd0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
      rx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      shift_q      <= shift_d;
      dout         <= dout_d;
      frame_err    <= ferr_d;
      rx_done_tick <= done_d;
      rx_q         <= rx_s;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pbit_q     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      pbit_q     <= pbit_d;
      parity_err <= perr_d;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    dout_d  = dout;
    ferr_d  = frame_err;
    done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbit_d  = pbit_q;
    perr_d  = parity_err;
`endif
    case (state_q)
      RX_IDLE: begin
        // rx_q gates the edge so a held-low line cannot retrigger
        if (rx_q && !rx_s) begin
          state_d = RX_START;
          s_d     = 5'd0;
        end
      end
      RX_START: begin
        if (s_tick) begin
          if (s_q == 5'(MID_TICK)) begin
            if (!rx_s) begin
              state_d = RX_DATA;
              s_d     = 5'd0;
              n_d     = 3'd0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      RX_DATA: begin
        if (s_tick) begin
          if (s_q == 5'(OVERSAMPLE - 1)) begin
            s_d     = 5'd0;
            shift_d = {rx_s, shift_q[7:1]};
            if (n_q == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = RX_PARITY;
`else
              state_d = RX_STOP;
`endif
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (s_tick) begin
          if (s_q == 5'(OVERSAMPLE - 1)) begin
            pbit_d  = rx_s;
            s_d     = 5'd0;
            state_d = RX_STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      RX_STOP: begin
        if (s_tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            dout_d  = aligned;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
            perr_d  = ((^aligned) ^ pbit_q) != PARITY_ODD;
`endif
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule
